// File: rtl/keysw_mmio.sv
// keysw_mmio: memory-mapped KEY/SW responder with 2-flop sync, debounce and sticky W1C status.
// Define KEYSW_IRQ_EN to add the IE register at BASE+14 and the registered irq output.
module keysw_mmio #(
   parameter int               DBITS      = 16,
   parameter logic [DBITS-1:0] BASE       = 16'hFFF0,
   parameter int               DEB_CYCLES = 50000,
   parameter int               CNTBITS    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       key_in,
   input  logic [9:0]       sw_in,
   input  logic [DBITS-1:0] addr,
   input  logic [DBITS-1:0] wdata,
   input  logic             we,
   output logic [DBITS-1:0] rdata,
   output logic             hit
`ifdef KEYSW_IRQ_EN
   ,
   output logic             irq
`endif
);

   localparam int                 NIN      = 14;
   localparam int                 ARMBITS  = CNTBITS + 1;
   localparam logic [NIN-1:0]     RST_LVL  = {10'h000, 4'hF};
   localparam logic [CNTBITS-1:0] DEB_LAST = CNTBITS'(DEB_CYCLES - 1);
   localparam logic [ARMBITS-1:0] ARM_AT   = ARMBITS'(DEB_CYCLES + 3);

   // Bit order everywhere: [3:0] keys, [13:4] switches.
   logic [NIN-1:0]     sync1, sync2, deb, upd;
   logic [CNTBITS-1:0] cnt [NIN];
   logic [ARMBITS-1:0] init_cnt;
   logic               armed;
   logic [3:0]         press, ovr, key_ev, clr_press, clr_ovr;
   logic [9:0]         chg, sw_ev, clr_chg;
   logic               in_win, wr_kstat, wr_sstat;
   logic [2:0]         off;
   logic [15:0]        rd16;
   logic               unused_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= RST_LVL;
         sync2 <= RST_LVL;
      end else begin
         sync1 <= {sw_in, key_in};
         sync2 <= sync1;
      end
   end

   always_comb begin
      upd = '0;
      for (int i = 0; i < NIN; i++) upd[i] = (sync2[i] != deb[i]) && (cnt[i] == DEB_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb <= RST_LVL;
         for (int i = 0; i < NIN; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NIN; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (upd[i]) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNTBITS'(1);
            end
         end
      end
   end

   // Events stay masked until the power-up levels have had time to settle through the debouncer.
   assign armed = (init_cnt == ARM_AT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      init_cnt <= '0;
      else if (!armed) init_cnt <= init_cnt + ARMBITS'(1);
   end

   assign key_ev = upd[3:0] & deb[3:0] & {4{armed}};
   assign sw_ev  = upd[NIN-1:4] & {10{armed}};

   assign in_win    = (addr[DBITS-1:4] == BASE[DBITS-1:4]);
   assign off       = addr[3:1];
   assign wr_kstat  = we && in_win && (off == 3'd2);
   assign wr_sstat  = we && in_win && (off == 3'd3);
   assign clr_press = wr_kstat ? wdata[3:0] : 4'h0;
   assign clr_ovr   = wr_kstat ? wdata[7:4] : 4'h0;
   assign clr_chg   = wr_sstat ? wdata[9:0] : 10'h000;

   // OR-ing the event after the clear mask makes a same-cycle set win over W1C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press <= 4'h0;
         ovr   <= 4'h0;
         chg   <= 10'h000;
      end else begin
         press <= (press & ~clr_press) | key_ev;
         ovr   <= (ovr & ~clr_ovr) | (key_ev & press);
         chg   <= (chg & ~clr_chg) | sw_ev;
      end
   end

`ifdef KEYSW_IRQ_EN
   logic [1:0] ie;
   logic       wr_ie;

   assign wr_ie = we && in_win && (off == 3'd7);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ie  <= 2'b00;
         irq <= 1'b0;
      end else begin
         if (wr_ie) ie <= wdata[1:0];
         irq <= (ie[0] & |press) | (ie[1] & |chg);
      end
   end
`endif

   always_comb begin
      rd16 = 16'h0000;
      hit  = 1'b0;
      if (in_win) begin
         case (off)
            3'd0: begin hit = 1'b1; rd16 = {12'h000, deb[3:0]};   end
            3'd1: begin hit = 1'b1; rd16 = {6'h00, deb[NIN-1:4]}; end
            3'd2: begin hit = 1'b1; rd16 = {8'h00, ovr, press};   end
            3'd3: begin hit = 1'b1; rd16 = {6'h00, chg};          end
`ifdef KEYSW_IRQ_EN
            3'd7: begin hit = 1'b1; rd16 = {14'h0000, ie};        end
`endif
            default: ;
         endcase
      end
   end

   assign rdata       = DBITS'(rd16);
   assign unused_bits = ^{addr[0], wdata[DBITS-1:10]};

endmodule

// File: tb/tb_keysw_mmio.sv
// tb_keysw_mmio: directed and randomized checks of keysw_mmio against a sample-window model.
// The model declares a level debounced once DEB consecutive synchronised samples disagree with it.
module tb_keysw_mmio;

   localparam int          DEB     = 4;
   localparam logic [15:0] BASE    = 16'hFFF0;
   localparam logic [15:0] A_KDATA = 16'hFFF0;
   localparam logic [15:0] A_SDATA = 16'hFFF2;
   localparam logic [15:0] A_KSTAT = 16'hFFF4;
   localparam logic [15:0] A_SSTAT = 16'hFFF6;
   localparam logic [15:0] A_IE    = 16'hFFFE;
   localparam logic [13:0] RST_LVL = {10'h000, 4'hF};

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [3:0]  key_in = 4'hF;
   logic [9:0]  sw_in  = 10'h000;
   logic [15:0] addr   = 16'h0000;
   logic [15:0] wdata  = 16'h0000;
   logic        we     = 1'b0;
   logic [15:0] rdata;
   logic        hit;
`ifdef KEYSW_IRQ_EN
   logic        irq;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   keysw_mmio #(.DBITS(16), .BASE(BASE), .DEB_CYCLES(DEB), .CNTBITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .key_in(key_in),
      .sw_in (sw_in),
      .addr  (addr),
      .wdata (wdata),
      .we    (we),
      .rdata (rdata),
      .hit   (hit)
`ifdef KEYSW_IRQ_EN
      ,
      .irq   (irq)
`endif
   );

   // ---------------- reference model ----------------
   logic [13:0] hist[$];   // pin samples, oldest first; the newest two are still in the synchroniser
   logic [13:0] m_deb;
   logic [3:0]  m_press, m_ovr;
   logic [9:0]  m_chg;
   int          m_age;
`ifdef KEYSW_IRQ_EN
   logic [1:0]  m_ie;
   logic        m_irq;
`endif

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < DEB + 2; k++) hist.push_back(RST_LVL);
      m_deb = RST_LVL; m_press = 4'h0; m_ovr = 4'h0; m_chg = 10'h000; m_age = 0;
`ifdef KEYSW_IRQ_EN
      m_ie = 2'b00; m_irq = 1'b0;
`endif
   endtask

   task automatic model_step();
      logic [13:0] nd;
      logic [3:0]  kev, clr_p, clr_o;
      logic [9:0]  sev, clr_c;
      logic        all_diff, armed;
      hist.push_back({sw_in, key_in});
      while (hist.size() > DEB + 2) void'(hist.pop_front());
      nd = m_deb;
      for (int b = 0; b < 14; b++) begin
         all_diff = 1'b1;
         for (int k = 0; k < DEB; k++) if (hist[k][b] == m_deb[b]) all_diff = 1'b0;
         if (all_diff) nd[b] = ~m_deb[b];
      end
      armed = (m_age >= DEB + 3);
      kev = armed ? (m_deb[3:0] & ~nd[3:0]) : 4'h0;
      sev = armed ? (m_deb[13:4] ^ nd[13:4]) : 10'h000;
      clr_p = 4'h0; clr_o = 4'h0; clr_c = 10'h000;
      if (we && {addr[15:1], 1'b0} == A_KSTAT) begin clr_p = wdata[3:0]; clr_o = wdata[7:4]; end
      if (we && {addr[15:1], 1'b0} == A_SSTAT) clr_c = wdata[9:0];
`ifdef KEYSW_IRQ_EN
      m_irq = (m_ie[0] && m_press != 0) || (m_ie[1] && m_chg != 0);
      if (we && {addr[15:1], 1'b0} == A_IE) m_ie = wdata[1:0];
`endif
      m_ovr   = (m_ovr & ~clr_o) | (kev & m_press);
      m_press = (m_press & ~clr_p) | kev;
      m_chg   = (m_chg & ~clr_c) | sev;
      m_deb   = nd;
      if (m_age < 1000) m_age++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   function automatic logic [16:0] exp_read(input logic [15:0] a);
      if (a[15:4] != BASE[15:4]) return 17'h0;
      case (a[3:1])
         3'd0: return {1'b1, 12'h000, m_deb[3:0]};
         3'd1: return {1'b1, 6'h00, m_deb[13:4]};
         3'd2: return {1'b1, 8'h00, m_ovr, m_press};
         3'd3: return {1'b1, 6'h00, m_chg};
`ifdef KEYSW_IRQ_EN
         3'd7: return {1'b1, 14'h0000, m_ie};
`endif
         default: return 17'h0;
      endcase
   endfunction

   // ---------------- drivers ----------------
   task automatic rd(input logic [15:0] a, output logic [15:0] d, output logic h);
      addr = a;
      #1;
      d = rdata;
      h = hit;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] v);
      @(negedge clk);
      addr = a; wdata = v; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [15:0] d; logic h;
      rst_n = 1'b0; sw_in = 10'h3FF; key_in = 4'hF; we = 1'b0;
      repeat (3) @(negedge clk);
      rd(A_KDATA, d, h); n_total++;
      if (h === 1'b1 && d === 16'h000F) n_pass++; else $display("FAIL reset_kdata: got hit=%b data=%h want hit=1 data=000f", h, d);
      rd(A_SDATA, d, h); n_total++;
      if (h === 1'b1 && d === 16'h0000) n_pass++; else $display("FAIL reset_sdata: got hit=%b data=%h want hit=1 data=0000", h, d);
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL reset_kstat: got %h want 0000", d);
`ifdef KEYSW_IRQ_EN
      n_total++;
      if (irq === 1'b0) n_pass++; else $display("FAIL reset_irq: got %b want 0", irq);
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_arming();
      logic [15:0] d; logic h;
      repeat (5) @(negedge clk);
      rd(A_SDATA, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL sdata_early: got %h want 0000", d);
      @(negedge clk);
      rd(A_SDATA, d, h); n_total++;
      if (d === 16'h03FF) n_pass++; else $display("FAIL sdata_cycle6: got %h want 03ff", d);
      repeat (6) @(negedge clk);
      rd(A_SSTAT, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL arming_sstat: got %h want 0000", d);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000F) n_pass++; else $display("FAIL arming_kdata: got %h want 000f", d);
   endtask

   task automatic test_glitch();
      logic [15:0] d; logic h;
      key_in[2] = 1'b0;
      repeat (3) @(negedge clk);
      key_in[2] = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         rd(A_KDATA, d, h); n_total++;
         if (d === 16'h000F) n_pass++; else $display("FAIL glitch_kdata c=%0d: got %h want 000f", c, d);
         rd(A_KSTAT, d, h); n_total++;
         if (d === 16'h0000) n_pass++; else $display("FAIL glitch_kstat c=%0d: got %h want 0000", c, d);
      end
   endtask

   task automatic test_press();
      logic [15:0] d; logic h;
      key_in[2] = 1'b0;
      repeat (5) @(negedge clk);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000F) n_pass++; else $display("FAIL press_early: got %h want 000f", d);
      @(negedge clk);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000B) n_pass++; else $display("FAIL press_kdata: got %h want 000b", d);
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0004) n_pass++; else $display("FAIL press_kstat: got %h want 0004", d);
      repeat (14) @(negedge clk);
      key_in[2] = 1'b1;
      repeat (10) @(negedge clk);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000F) n_pass++; else $display("FAIL release_kdata: got %h want 000f", d);
      rd(16'hFFF5, d, h); n_total++;
      if (h === 1'b1 && d === 16'h0004) n_pass++; else $display("FAIL odd_addr_kstat: got hit=%b data=%h want hit=1 data=0004", h, d);
      key_in[2] = 1'b0;
      repeat (10) @(negedge clk);
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0044) n_pass++; else $display("FAIL overrun_kstat: got %h want 0044", d);
      key_in[2] = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_w1c_race();
      logic [15:0] d; logic h;
      key_in[0] = 1'b0;
      repeat (5) @(negedge clk);
      addr = A_KSTAT; wdata = 16'h0044; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0001) n_pass++; else $display("FAIL set_wins_kstat: got %h want 0001", d);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000E) n_pass++; else $display("FAIL set_wins_kdata: got %h want 000e", d);
      key_in[0] = 1'b1;
      repeat (10) @(negedge clk);
      wr(A_KSTAT, 16'h00FF);
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL kstat_clear_all: got %h want 0000", d);
   endtask

   task automatic test_switch();
      logic [15:0] d; logic h;
      sw_in[9] = 1'b0;
      repeat (8) @(negedge clk);
      rd(A_SSTAT, d, h); n_total++;
      if (d === 16'h0200) n_pass++; else $display("FAIL switch_sstat: got %h want 0200", d);
      rd(A_SDATA, d, h); n_total++;
      if (d === 16'h01FF) n_pass++; else $display("FAIL switch_sdata: got %h want 01ff", d);
      wr(A_SSTAT, 16'h0200);
      rd(A_SSTAT, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL sstat_w1c: got %h want 0000", d);
      wr(A_SDATA, 16'h1234);
      rd(A_SDATA, d, h); n_total++;
      if (d === 16'h01FF) n_pass++; else $display("FAIL sdata_readonly: got %h want 01ff", d);
      wr(A_KDATA, 16'h0000);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000F) n_pass++; else $display("FAIL kdata_readonly: got %h want 000f", d);
      rd(16'hFFF8, d, h); n_total++;
      if (h === 1'b0 && d === 16'h0000) n_pass++; else $display("FAIL hole_fff8: got hit=%b data=%h want hit=0 data=0000", h, d);
      rd(16'hFFE6, d, h); n_total++;
      if (h === 1'b0 && d === 16'h0000) n_pass++; else $display("FAIL outside_ffe6: got hit=%b data=%h want hit=0 data=0000", h, d);
   endtask

   task automatic test_irq();
      logic [15:0] d; logic h;
`ifdef KEYSW_IRQ_EN
      wr(A_IE, 16'hFFFD);
      rd(A_IE, d, h); n_total++;
      if (h === 1'b1 && d === 16'h0001) n_pass++; else $display("FAIL ie_read: got hit=%b data=%h want hit=1 data=0001", h, d);
      key_in[1] = 1'b0;
      repeat (6) @(negedge clk);
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0002 && irq === 1'b0) n_pass++; else $display("FAIL irq_lag: got kstat=%h irq=%b want kstat=0002 irq=0", d, irq);
      @(negedge clk);
      n_total++;
      if (irq === 1'b1) n_pass++; else $display("FAIL irq_assert: got %b want 1", irq);
      key_in[1] = 1'b1;
      wr(A_KSTAT, 16'h0002);
      n_total++;
      if (irq === 1'b1) n_pass++; else $display("FAIL irq_hold_on_clear_edge: got %b want 1", irq);
      @(negedge clk);
      n_total++;
      if (irq === 1'b0) n_pass++; else $display("FAIL irq_deassert: got %b want 0", irq);
      repeat (8) @(negedge clk);
      wr(A_IE, 16'h0000);
      key_in[3] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_total++;
         if (irq === 1'b0) n_pass++; else $display("FAIL irq_disabled c=%0d: got %b want 0", c, irq);
      end
      key_in[3] = 1'b1;
      repeat (8) @(negedge clk);
      wr(A_KSTAT, 16'h00FF);
`else
      rd(A_IE, d, h); n_total++;
      if (h === 1'b0 && d === 16'h0000) n_pass++; else $display("FAIL no_ie_read: got hit=%b data=%h want hit=0 data=0000", h, d);
      wr(A_IE, 16'h0003);
      rd(A_IE, d, h); n_total++;
      if (h === 1'b0 && d === 16'h0000) n_pass++; else $display("FAIL no_ie_after_write: got hit=%b data=%h want hit=0 data=0000", h, d);
`endif
   endtask

   task automatic test_reset_mid();
      logic [15:0] d; logic h;
      key_in[3] = 1'b0;
      repeat (8) @(negedge clk);
      key_in[3] = 1'b1;
      repeat (8) @(negedge clk);
      key_in[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL midreset_kstat: got %h want 0000", d);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000F) n_pass++; else $display("FAIL midreset_kdata: got %h want 000f", d);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      rd(A_KDATA, d, h); n_total++;
      if (d === 16'h000D) n_pass++; else $display("FAIL post_reset_kdata: got %h want 000d", d);
      rd(A_KSTAT, d, h); n_total++;
      if (d === 16'h0000) n_pass++; else $display("FAIL post_reset_unarmed_kstat: got %h want 0000", d);
      key_in[1] = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      logic [15:0] a, d;
      logic [16:0] e;
      logic        h;
      int          b;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         we = 1'b0;
         for (int j = 0; j < 4; j++) begin
            a = BASE + 16'(2 * j) + 16'($urandom_range(0, 1));
            rd(a, d, h);
            e = exp_read(a);
            n_total++;
            if ({h, d} === e) n_pass++;
            else $display("FAIL random_read c=%0d addr=%h: got hit=%b data=%h want hit=%b data=%h", c, a, h, d, e[16], e[15:0]);
         end
`ifdef KEYSW_IRQ_EN
         n_total++;
         if (irq === m_irq) n_pass++; else $display("FAIL random_irq c=%0d: got %b want %b", c, irq, m_irq);
`endif
         if ($urandom_range(0, 5) == 0) begin
            b = int'($urandom_range(0, 13));
            if (b < 4) key_in[b] = ~key_in[b];
            else       sw_in[b-4] = ~sw_in[b-4];
         end
         if ($urandom_range(0, 11) == 0) begin
            addr  = BASE + 16'(2 * $urandom_range(0, 7));
            wdata = 16'($urandom);
            we    = 1'b1;
         end
      end
      @(negedge clk);
      we = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_arming();
      test_glitch();
      test_press();
      test_w1c_race();
      test_switch();
      test_irq();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
